// File: rtl/game_io_controller.sv
// game_io_controller: processor game-I/O registers, game-state sequencer and
// PS2 space-key handshake.
//   clock, resetn            : clock, asynchronous active-low reset
//   cpu_wr_state/bird/score  : single-cycle write strobes (priority state > bird > score)
//   cpu_wdata                : shared write data
//   cpu_key_ack              : software consumed the key event
//   space_state              : PS2 key event (0 none, 1 press, 2/3 release)
//   reset_space_state        : acknowledge back to PS2
//   key_pending              : coalesced unconsumed space press
//   game_state, bird_y, score, seed, random_reset, bad_write : registered outputs
module game_io_controller #(
  parameter int signed   BIRD_Y_MIN = 0,
  parameter int signed   BIRD_Y_MAX = 479,
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned ACK_HOLD   = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_wr_state,
  input  logic        cpu_wr_bird,
  input  logic        cpu_wr_score,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_key_ack,
  input  logic [1:0]  space_state,
  output logic        reset_space_state,
  output logic        key_pending,
  output logic [1:0]  game_state,
  output logic [31:0] bird_y,
  output logic [31:0] score,
  output logic [31:0] seed,
  output logic        random_reset,
  output logic        bad_write
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {GS_TITLE = 2'd0, GS_PLAY = 2'd1, GS_OVER = 2'd2} game_state_e;
  typedef enum logic [1:0] {K_IDLE = 2'd0, K_ACK = 2'd1, K_CLEAR = 2'd2} key_state_e;

  game_state_e         gs_q, gs_d;
  key_state_e          ks_q, ks_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   bird_q, bird_d, score_q, score_d, seed_q, seed_d;
  logic                rss_q, rss_d, kp_q, kp_d, rr_q, rr_d, bw_q, bw_d;

  // Register bank
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gs_q    <= GS_TITLE;
      ks_q    <= K_IDLE;
      hold_q  <= '0;
      bird_q  <= DATA_W'(BIRD_Y_MIN);
      score_q <= '0;
      seed_q  <= '0;
      rss_q   <= 1'b0;
      kp_q    <= 1'b0;
      rr_q    <= 1'b0;
      bw_q    <= 1'b0;
    end else begin
      gs_q    <= gs_d;
      ks_q    <= ks_d;
      hold_q  <= hold_d;
      bird_q  <= bird_d;
      score_q <= score_d;
      seed_q  <= seed_d;
      rss_q   <= rss_d;
      kp_q    <= kp_d;
      rr_q    <= rr_d;
      bw_q    <= bw_d;
    end
  end

  // Processor write path and game-state sequencer
  logic              multi_strobe;
  logic              state_legal;
  logic              bad;
  logic signed [DATA_W-1:0] wdata_s;
  game_state_e       gs_new;

  always_comb begin
    gs_d         = gs_q;
    bird_d       = bird_q;
    score_d      = score_q;
    seed_d       = DATA_W'(seed_q + DATA_W'(1));
    rr_d         = 1'b0;
    bad          = 1'b0;
    wdata_s      = $signed(cpu_wdata);
    gs_new       = game_state_e'(cpu_wdata[1:0]);
    multi_strobe = (cpu_wr_state & cpu_wr_bird) | (cpu_wr_state & cpu_wr_score) |
                   (cpu_wr_bird & cpu_wr_score);
    state_legal  = (cpu_wdata[31:2] == '0) &&
                   ((gs_new == gs_q) ||
                    (gs_q == GS_TITLE && gs_new == GS_PLAY) ||
                    (gs_q == GS_PLAY  && gs_new == GS_OVER) ||
                    (gs_q == GS_OVER  && gs_new == GS_TITLE));

    if (cpu_wr_state) begin
      if (state_legal) begin
        gs_d = gs_new;
        // Starting a new game resets the playfield and reseeds the PRNG
        if (gs_q == GS_TITLE && gs_new == GS_PLAY) begin
          score_d = '0;
          bird_d  = DATA_W'(BIRD_Y_MIN);
          rr_d    = 1'b1;
        end
      end else begin
        bad = 1'b1;
      end
    end else if (cpu_wr_bird) begin
      if (wdata_s < BIRD_Y_MIN)      bird_d = DATA_W'(BIRD_Y_MIN);
      else if (wdata_s > BIRD_Y_MAX) bird_d = DATA_W'(BIRD_Y_MAX);
      else                           bird_d = cpu_wdata;
    end else if (cpu_wr_score) begin
      if (gs_q != GS_PLAY)                   bad     = 1'b1;
      else if (cpu_wdata > DATA_W'(SCORE_MAX)) score_d = DATA_W'(SCORE_MAX);
      else                                   score_d = cpu_wdata;
    end

    bw_d = bw_q | bad | multi_strobe;
  end

  // Key handshake FSM; a press seen in K_IDLE beats a coincident ack
  always_comb begin
    ks_d   = ks_q;
    hold_d = hold_q;
    rss_d  = 1'b0;
    kp_d   = kp_q & ~cpu_key_ack;
    unique case (ks_q)
      K_IDLE: begin
        if (space_state != 2'd0) begin
          ks_d   = K_ACK;
          hold_d = HOLD_W'(1);
          rss_d  = 1'b1;
          if (space_state == 2'd1) kp_d = 1'b1;
        end
      end
      K_ACK: begin
        if (hold_q == HOLD_W'(ACK_HOLD)) begin
          ks_d = K_CLEAR;
        end else begin
          hold_d = HOLD_W'(hold_q + HOLD_W'(1));
          rss_d  = 1'b1;
        end
      end
      K_CLEAR: begin
        if (space_state == 2'd0) ks_d = K_IDLE;
      end
      default: ks_d = K_IDLE;
    endcase
  end

  assign reset_space_state = rss_q;
  assign key_pending       = kp_q;
  assign game_state        = gs_q;
  assign bird_y            = bird_q;
  assign score             = score_q;
  assign seed              = seed_q;
  assign random_reset      = rr_q;
  assign bad_write         = bw_q;

endmodule

// File: tb/tb_game_io_controller.sv
module tb_game_io_controller;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_wr_state = 1'b0, cpu_wr_bird = 1'b0, cpu_wr_score = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_key_ack = 1'b0;
  logic [1:0]  space_state = 2'd0;
  logic        reset_space_state, key_pending, random_reset, bad_write;
  logic [1:0]  game_state;
  logic [31:0] bird_y, score, seed;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef enum int {S_GS, S_BIRD, S_SCORE, S_SEED, S_RR, S_BW, S_KP, S_RSS} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  game_io_controller dut (
    .clock(clock), .resetn(resetn),
    .cpu_wr_state(cpu_wr_state), .cpu_wr_bird(cpu_wr_bird), .cpu_wr_score(cpu_wr_score),
    .cpu_wdata(cpu_wdata), .cpu_key_ack(cpu_key_ack), .space_state(space_state),
    .reset_space_state(reset_space_state), .key_pending(key_pending),
    .game_state(game_state), .bird_y(bird_y), .score(score), .seed(seed),
    .random_reset(random_reset), .bad_write(bad_write)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_GS:    return 32'(game_state);
      S_BIRD:  return bird_y;
      S_SCORE: return score;
      S_SEED:  return seed;
      S_RR:    return 32'(random_reset);
      S_BW:    return 32'(bad_write);
      S_KP:    return 32'(key_pending);
      default: return 32'(reset_space_state);
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      tests++;
      assert (o === e.val) else begin
        fails++;
        $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", e.tag, o, o, e.val, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (resetn) cyc++;
    cpu_wr_state = 1'b0; cpu_wr_bird = 1'b0; cpu_wr_score = 1'b0; cpu_key_ack = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    space_state = 2'd0;
    tick();
    tick();
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic wr(input logic s, input logic b, input logic c, input logic [31:0] d);
    cpu_wr_state = s; cpu_wr_bird = b; cpu_wr_score = c; cpu_wdata = d;
  endtask

  task automatic expect_regs(input string tag, input logic [1:0] g, input logic [31:0] b,
                             input logic [31:0] s, input logic bw);
    expect_v({tag, "_gs"}, S_GS, 32'(g));
    expect_v({tag, "_bird"}, S_BIRD, b);
    expect_v({tag, "_score"}, S_SCORE, s);
    expect_v({tag, "_bw"}, S_BW, 32'(bw));
  endtask

  initial begin
    // Reset values held in reset
    #2;
    expect_regs("in_reset", 2'd0, 32'd0, 32'd0, 1'b0);
    expect_v("in_reset_seed", S_SEED, 32'd0);
    expect_v("in_reset_rss", S_RSS, 32'd0);
    check();
    do_reset();
    repeat (5) tick();
    expect_regs("idle5", 2'd0, 32'd0, 32'd0, 1'b0);
    expect_v("idle5_seed", S_SEED, 32'(cyc));
    expect_v("idle5_rr", S_RR, 32'd0);
    expect_v("idle5_kp", S_KP, 32'd0);
    expect_v("idle5_rss", S_RSS, 32'd0);
    check();

    // Score write in title is rejected
    wr(1'b0, 1'b0, 1'b1, 32'd7); tick();
    expect_regs("score_title", 2'd0, 32'd0, 32'd0, 1'b1);
    check();

    // Title -> play, random_reset single pulse, same-state no-op, illegal 1->0
    do_reset();
    wr(1'b1, 1'b0, 1'b0, 32'd1); tick();
    expect_regs("t2p", 2'd1, 32'd0, 32'd0, 1'b0);
    expect_v("t2p_rr", S_RR, 32'd1);
    check();
    wr(1'b1, 1'b0, 1'b0, 32'd1); tick();
    expect_regs("p2p_noop", 2'd1, 32'd0, 32'd0, 1'b0);
    expect_v("p2p_rr", S_RR, 32'd0);
    check();
    wr(1'b1, 1'b0, 1'b0, 32'd0); tick();
    expect_regs("p2t_rej", 2'd1, 32'd0, 32'd0, 1'b1);
    check();

    // Play: clamps, saturation, sequencing back to title keeps values
    do_reset();
    wr(1'b1, 1'b0, 1'b0, 32'd1); tick();
    wr(1'b0, 1'b0, 1'b1, 32'd12000); tick();
    expect_v("score_sat", S_SCORE, 32'd9999); check();
    wr(1'b0, 1'b1, 1'b0, -32'sd20); tick();
    expect_v("bird_lo", S_BIRD, 32'd0); check();
    wr(1'b0, 1'b1, 1'b0, 32'd600); tick();
    expect_v("bird_hi", S_BIRD, 32'd479); check();
    wr(1'b0, 1'b1, 1'b0, 32'd123); tick();
    expect_v("bird_mid", S_BIRD, 32'd123); check();
    wr(1'b0, 1'b0, 1'b1, 32'd9999); tick();
    expect_v("score_edge", S_SCORE, 32'd9999); check();
    wr(1'b0, 1'b0, 1'b1, 32'd42); tick();
    expect_v("score_mid", S_SCORE, 32'd42); check();
    wr(1'b1, 1'b0, 1'b0, 32'd2); tick();
    expect_regs("p2o", 2'd2, 32'd123, 32'd42, 1'b0); check();
    wr(1'b1, 1'b0, 1'b0, 32'd0); tick();
    expect_regs("o2t_keep", 2'd0, 32'd123, 32'd42, 1'b0); check();
    wr(1'b1, 1'b0, 1'b0, 32'd1); tick();
    expect_regs("t2p_clear", 2'd1, 32'd0, 32'd0, 1'b0);
    expect_v("t2p_clear_rr", S_RR, 32'd1); check();
    wr(1'b1, 1'b0, 1'b0, 32'h0000_0006); tick();
    expect_regs("hi_bits_rej", 2'd1, 32'd0, 32'd0, 1'b1);
    expect_v("hi_bits_rr", S_RR, 32'd0); check();

    // Simultaneous strobes: only the state write lands
    do_reset();
    wr(1'b1, 1'b1, 1'b1, 32'd1); tick();
    expect_regs("multi", 2'd1, 32'd0, 32'd0, 1'b1); check();

    // Key press handshake: space held 4 cycles
    do_reset();
    space_state = 2'd1; tick();
    expect_v("press_rss0", S_RSS, 32'd1);
    expect_v("press_kp", S_KP, 32'd1); check();
    tick();
    expect_v("press_rss1", S_RSS, 32'd1); check();
    tick();
    expect_v("press_rss2", S_RSS, 32'd0); check();
    cpu_key_ack = 1'b1; tick();
    expect_v("clear_hold_ack", S_KP, 32'd0);
    expect_v("clear_hold_rss", S_RSS, 32'd0); check();
    space_state = 2'd0; tick();
    expect_v("back_idle_kp", S_KP, 32'd0); check();
    // Press coincident with ack: set wins
    space_state = 2'd1; cpu_key_ack = 1'b1; tick();
    expect_v("ack_vs_press_kp", S_KP, 32'd1);
    expect_v("ack_vs_press_rss", S_RSS, 32'd1); check();
    space_state = 2'd0; tick(); tick(); tick();
    cpu_key_ack = 1'b1; tick();
    expect_v("ack_clear", S_KP, 32'd0); check();

    // Asynchronous reset mid-ACK, then a release event
    space_state = 2'd1; tick();
    expect_v("pre_rst_rss", S_RSS, 32'd1); check();
    resetn = 1'b0; #1;
    expect_v("async_rst_rss", S_RSS, 32'd0);
    expect_v("async_rst_kp", S_KP, 32'd0); check();
    space_state = 2'd0; tick();
    resetn = 1'b1; cyc = 0;
    space_state = 2'd2; tick();
    expect_v("rel_rss0", S_RSS, 32'd1);
    expect_v("rel_kp", S_KP, 32'd0); check();
    space_state = 2'd0; tick();
    expect_v("rel_rss1", S_RSS, 32'd1); check();
    tick();
    expect_v("rel_rss2", S_RSS, 32'd0);
    expect_v("rel_kp_end", S_KP, 32'd0);
    expect_v("rel_seed", S_SEED, 32'(cyc)); check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
